// File: rtl/mux_ulaa_demux_reg_if.sv
// Bus between the control unit/ALU side and the registered 1:4 result demux.
// The master drives the capture strobes and acknowledges; the slave is the demux.
interface mux_ulaa_demux_reg_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
);
    logic [1:0]            selector;
    logic                  load;
    logic [DATA_WIDTH-1:0] input_data;
    logic [3:0]            consume;
    logic                  clear_err;
    logic [DATA_WIDTH-1:0] output_one;
    logic [DATA_WIDTH-1:0] output_two;
    logic [DATA_WIDTH-1:0] output_three;
    logic [DATA_WIDTH-1:0] output_four;
    logic [3:0]            valid;
    logic                  overwrite_err;
    logic [1:0]            err_slot;
    logic [CNT_WIDTH-1:0]  load_count;

    modport master (
        output selector, load, input_data, consume, clear_err,
        input  output_one, output_two, output_three, output_four,
        input  valid, overwrite_err, err_slot, load_count
    );

    modport slave (
        input  selector, load, input_data, consume, clear_err,
        output output_one, output_two, output_three, output_four,
        output valid, overwrite_err, err_slot, load_count
    );
endinterface

// File: rtl/mux_ulaa_demux_reg.sv
// Registered 1:4 demux on the ALU result path: four holding slots with valid
// flags, consume acknowledges, a sticky overwrite-error latch and a load counter.
module mux_ulaa_demux_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    mux_ulaa_demux_reg_if.slave    bus
);
    logic [DATA_WIDTH-1:0] slot_q [4];
    logic [DATA_WIDTH-1:0] slot_d [4];
    logic [3:0]            valid_q, valid_d;
    logic                  err_q, err_d;
    logic [1:0]            err_slot_q, err_slot_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  overwrite;

    // A same-cycle consume on the target slot frees it, so that is not an overwrite.
    assign overwrite = bus.load && valid_q[bus.selector] && !bus.consume[bus.selector];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            slot_d[i] = slot_q[i];
        end
        valid_d    = valid_q & ~bus.consume;
        err_d      = err_q;
        err_slot_d = err_slot_q;
        cnt_d      = cnt_q;

        if (bus.load) begin
            slot_d[bus.selector]  = bus.input_data;
            valid_d[bus.selector] = 1'b1;
            if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (bus.clear_err) begin
            err_d      = 1'b0;
            err_slot_d = 2'd0;
        end

        // Set beats clear; only the first overwrite since the latch was empty records its slot.
        if (overwrite) begin
            err_d = 1'b1;
            if (!err_q || bus.clear_err) begin
                err_slot_d = bus.selector;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= '0;
            end
            valid_q    <= 4'b0000;
            err_q      <= 1'b0;
            err_slot_q <= 2'd0;
            cnt_q      <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= slot_d[i];
            end
            valid_q    <= valid_d;
            err_q      <= err_d;
            err_slot_q <= err_slot_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.output_one    = slot_q[0];
    assign bus.output_two    = slot_q[1];
    assign bus.output_three  = slot_q[2];
    assign bus.output_four   = slot_q[3];
    assign bus.valid         = valid_q;
    assign bus.overwrite_err = err_q;
    assign bus.err_slot      = err_slot_q;
    assign bus.load_count    = cnt_q;
endmodule

// File: tb/tb_mux_ulaa_demux_reg.sv
// Directed bench for the registered 1:4 ALU result demux.
module tb_mux_ulaa_demux_reg;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mux_ulaa_demux_reg_if #(.DATA_WIDTH(32), .CNT_WIDTH(8)) bus ();

    mux_ulaa_demux_reg #(.DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic ld, input logic [1:0] sel, input logic [31:0] data,
                        input logic [3:0] cons, input logic clr);
        bus.load       = ld;
        bus.selector   = sel;
        bus.input_data = data;
        bus.consume    = cons;
        bus.clear_err  = clr;
        @(posedge clk);
        #1;
        bus.load      = 1'b0;
        bus.consume   = 4'b0000;
        bus.clear_err = 1'b0;
    endtask

    task automatic chk_slots(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
        chk({tag, "_out1"}, bus.output_one,   e0);
        chk({tag, "_out2"}, bus.output_two,   e1);
        chk({tag, "_out3"}, bus.output_three, e2);
        chk({tag, "_out4"}, bus.output_four,  e3);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus.load       = 1'b0;
        bus.selector   = 2'd0;
        bus.input_data = 32'h0;
        bus.consume    = 4'b0000;
        bus.clear_err  = 1'b0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step(1'b0, 2'd0, 32'h0, 4'b0000, 1'b0);
        chk_slots("rst", 32'h0, 32'h0, 32'h0, 32'h0);
        chk("rst_valid", {28'h0, bus.valid}, 32'h0);
        chk("rst_err",   {31'h0, bus.overwrite_err}, 32'h0);
        chk("rst_eslot", {30'h0, bus.err_slot}, 32'h0);
        chk("rst_cnt",   {24'h0, bus.load_count}, 32'h0);

        // Routing
        step(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000, 1'b0);
        chk_slots("route2", 32'h0, 32'h0, 32'hDEADBEEF, 32'h0);
        chk("route2_valid", {28'h0, bus.valid}, 32'h4);
        chk("route2_cnt",   {24'h0, bus.load_count}, 32'd1);
        step(1'b1, 2'd0, 32'hA0A0A0A0, 4'b0000, 1'b0);
        chk_slots("route0", 32'hA0A0A0A0, 32'h0, 32'hDEADBEEF, 32'h0);
        step(1'b1, 2'd1, 32'hB1B1B1B1, 4'b0000, 1'b0);
        chk_slots("route1", 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hDEADBEEF, 32'h0);
        step(1'b1, 2'd3, 32'hC3C3C3C3, 4'b0000, 1'b0);
        chk_slots("route3", 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hDEADBEEF, 32'hC3C3C3C3);
        chk("route_valid", {28'h0, bus.valid}, 32'hF);
        chk("route_cnt",   {24'h0, bus.load_count}, 32'd4);
        chk("route_err",   {31'h0, bus.overwrite_err}, 32'h0);

        // Consume
        step(1'b0, 2'd0, 32'h0, 4'b0101, 1'b0);
        chk("cons_valid", {28'h0, bus.valid}, 32'hA);
        chk_slots("cons", 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hDEADBEEF, 32'hC3C3C3C3);
        chk("cons_err", {31'h0, bus.overwrite_err}, 32'h0);
        chk("cons_cnt", {24'h0, bus.load_count}, 32'd4);
        step(1'b0, 2'd0, 32'h0, 4'b1111, 1'b0);
        chk("cons_all_valid", {28'h0, bus.valid}, 32'h0);

        // Overwrite
        step(1'b1, 2'd1, 32'h1111, 4'b0000, 1'b0);
        chk("ow_first_err", {31'h0, bus.overwrite_err}, 32'h0);
        step(1'b1, 2'd1, 32'h2222, 4'b0000, 1'b0);
        chk("ow_out2",  bus.output_two, 32'h2222);
        chk("ow_err",   {31'h0, bus.overwrite_err}, 32'h1);
        chk("ow_eslot", {30'h0, bus.err_slot}, 32'd1);
        step(1'b1, 2'd3, 32'h3333, 4'b0000, 1'b0);
        step(1'b1, 2'd3, 32'h4444, 4'b0000, 1'b0);
        chk("ow3_out4",  bus.output_four, 32'h4444);
        chk("ow3_err",   {31'h0, bus.overwrite_err}, 32'h1);
        chk("ow3_eslot", {30'h0, bus.err_slot}, 32'd1);
        step(1'b0, 2'd0, 32'h0, 4'b0000, 1'b1);
        chk("clr_err",   {31'h0, bus.overwrite_err}, 32'h0);
        chk("clr_eslot", {30'h0, bus.err_slot}, 32'd0);
        chk("clr_cnt",   {24'h0, bus.load_count}, 32'd8);

        // Simultaneous load and consume on the same slot
        step(1'b1, 2'd0, 32'h00000A0A, 4'b0000, 1'b0);
        step(1'b1, 2'd0, 32'h00000B0B, 4'b0001, 1'b0);
        chk("lc_out1",  bus.output_one, 32'h00000B0B);
        chk("lc_valid", {28'h0, bus.valid}, 32'hB);
        chk("lc_err",   {31'h0, bus.overwrite_err}, 32'h0);

        // Clear together with an overwrite: set wins
        step(1'b1, 2'd2, 32'h22, 4'b0000, 1'b0);
        step(1'b1, 2'd2, 32'h33, 4'b0000, 1'b1);
        chk("cs_out3",  bus.output_three, 32'h33);
        chk("cs_err",   {31'h0, bus.overwrite_err}, 32'h1);
        chk("cs_eslot", {30'h0, bus.err_slot}, 32'd2);
        chk("cs_cnt",   {24'h0, bus.load_count}, 32'd12);

        // Counter saturation
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 2'd0, i, 4'b0001, 1'b0);
            if (i == 242) chk("sat_at_255", {24'h0, bus.load_count}, 32'd255);
        end
        chk("sat_cnt",  {24'h0, bus.load_count}, 32'd255);
        chk("sat_out1", bus.output_one, 32'd299);
        repeat (3) step(1'b0, 2'd0, 32'h0, 4'b0000, 1'b0);
        chk("sat_hold", {24'h0, bus.load_count}, 32'd255);
        chk("idle_out1", bus.output_one, 32'd299);

        // Asynchronous reset mid-cycle
        #1 reset = 1'b1;
        #1;
        chk_slots("arst", 32'h0, 32'h0, 32'h0, 32'h0);
        chk("arst_valid", {28'h0, bus.valid}, 32'h0);
        chk("arst_err",   {31'h0, bus.overwrite_err}, 32'h0);
        chk("arst_eslot", {30'h0, bus.err_slot}, 32'h0);
        chk("arst_cnt",   {24'h0, bus.load_count}, 32'h0);
        step(1'b1, 2'd1, 32'h5555, 4'b0000, 1'b0);
        chk("arst_hold_out2", bus.output_two, 32'h0);
        chk("arst_hold_cnt",  {24'h0, bus.load_count}, 32'h0);
        reset = 1'b0;
        step(1'b1, 2'd1, 32'h6666, 4'b0000, 1'b0);
        chk("post_rst_out2", bus.output_two, 32'h6666);
        chk("post_rst_cnt",  {24'h0, bus.load_count}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
